// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Brief    : Shared constants and types for the seven-segment receiver.
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Active-low patterns, bit0=a ... bit6=g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [0:0] {
        BLANK  = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        logic       err;
        logic [3:0] digit;
    } fifo_entry_t;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_lookup.sv
`default_nettype none
// ============================================================================
// Module   : seg_lookup
// Brief    : Combinational segment-pattern to hex-digit lookup.
// Revision : 1.0 - initial release
// ============================================================================
module seg_lookup
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       hit
);

    always_comb begin
        digit = 4'h0;
        hit   = 1'b1;
        case (seg)
            SEG_0:   digit = 4'h0;
            SEG_1:   digit = 4'h1;
            SEG_2:   digit = 4'h2;
            SEG_3:   digit = 4'h3;
            SEG_4:   digit = 4'h4;
            SEG_5:   digit = 4'h5;
            SEG_6:   digit = 4'h6;
            SEG_7:   digit = 4'h7;
            SEG_8:   digit = 4'h8;
            SEG_9:   digit = 4'h9;
            SEG_A:   digit = 4'hA;
            SEG_B:   digit = 4'hB;
            SEG_C:   digit = 4'hC;
            SEG_D:   digit = 4'hD;
            SEG_E:   digit = 4'hE;
            SEG_F:   digit = 4'hF;
            default: hit   = 1'b0;
        endcase
    end

endmodule : seg_lookup
`default_nettype wire

// File: rtl/seg_decoder_rx.sv
`default_nettype none
// ============================================================================
// Module   : seg_decoder_rx
// Brief    : Debounces an observed 7-segment pattern, decodes it and buffers
//            the digits in a first-word-fall-through FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module seg_decoder_rx
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] seg_in,
    output logic [3:0] out_digit,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow
);

    localparam int         c_addr_w = $clog2(FIFO_DEPTH);
    localparam logic [3:0] c_stable = 4'(STABLE_CYCLES);

    // ---------------- stability filter ----------------
    logic [6:0] r_samp;
    logic [3:0] r_cnt;
    logic       w_same;
    logic       w_stable;

    assign w_same   = (seg_in == r_samp);
    // Stable on the edge where the count reaches its saturation value
    assign w_stable = w_same && (r_cnt == (c_stable - 4'd1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_samp <= SEG_BLANK;
            r_cnt  <= 4'd1;
        end else begin
            r_samp <= seg_in;
            if (!w_same)
                r_cnt <= 4'd1;
            else if (r_cnt != c_stable)
                r_cnt <= r_cnt + 4'd1;
        end
    end

    // ---------------- decode ----------------
    logic [3:0]  w_lk_digit;
    logic        w_lk_hit;
    fifo_entry_t w_push_data;

    seg_lookup u_lookup (
        .seg   (r_samp),
        .digit (w_lk_digit),
        .hit   (w_lk_hit)
    );

    assign w_push_data.err   = !w_lk_hit;
    assign w_push_data.digit = w_lk_hit ? w_lk_digit : 4'd0;

    // ---------------- tracking FSM ----------------
    state_t     r_state;
    logic [6:0] r_accepted;
    logic       w_push_req;

    assign w_push_req = w_stable && (r_samp != SEG_BLANK) &&
                        ((r_state == BLANK) || (r_samp != r_accepted));

    // Tracking advances even when the FIFO drops the push
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= BLANK;
            r_accepted <= SEG_BLANK;
        end else if (w_stable) begin
            if (r_samp == SEG_BLANK) begin
                r_state <= BLANK;
            end else begin
                r_state    <= LOCKED;
                r_accepted <= r_samp;
            end
        end
    end

    // ---------------- FWFT FIFO ----------------
    fifo_entry_t         r_mem [FIFO_DEPTH];
    logic [c_addr_w:0]   r_wptr;
    logic [c_addr_w:0]   r_rptr;
    logic [c_addr_w:0]   w_wptr_nxt;
    logic [c_addr_w:0]   w_rptr_nxt;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                r_out_valid;
    logic                r_overflow;
    fifo_entry_t         r_out;
    fifo_entry_t         w_head_nxt;

    assign w_full = (r_wptr[c_addr_w] != r_rptr[c_addr_w]) &&
                    (r_wptr[c_addr_w-1:0] == r_rptr[c_addr_w-1:0]);
    assign w_pop  = out_ready && r_out_valid;
    assign w_push = w_push_req && (!w_full || w_pop);

    assign w_wptr_nxt = r_wptr + (c_addr_w+1)'(w_push);
    assign w_rptr_nxt = r_rptr + (c_addr_w+1)'(w_pop);

    // Bypass the write data when the slot being written becomes the head
    always_comb begin
        w_head_nxt = r_mem[w_rptr_nxt[c_addr_w-1:0]];
        if (w_push && (r_wptr[c_addr_w-1:0] == w_rptr_nxt[c_addr_w-1:0]))
            w_head_nxt = w_push_data;
    end

    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wptr[c_addr_w-1:0]] <= w_push_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_wptr      <= w_wptr_nxt;
            r_rptr      <= w_rptr_nxt;
            r_out_valid <= (w_wptr_nxt != w_rptr_nxt);
            r_out       <= (w_wptr_nxt != w_rptr_nxt) ? w_head_nxt : '0;
            if (w_push_req && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end

    assign out_digit = r_out.digit;
    assign out_err   = r_out.err;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;

endmodule : seg_decoder_rx
`default_nettype wire

// File: tb/tb_seg_decoder_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_decoder_rx
// Brief    : Scoreboard bench for seg_decoder_rx with directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_decoder_rx;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] seg_in;
    logic [3:0] out_digit;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    int         vcnt   = 0;
    logic [4:0] exp_q[$];

    seg_decoder_rx #(
        .STABLE_CYCLES (4),
        .FIFO_DEPTH    (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .seg_in    (seg_in),
        .out_digit (out_digit),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: handshake seen at negedge completes on the following posedge
    always @(negedge clock) begin
        logic [4:0] e;
        if (!reset && out_valid) vcnt++;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_entry actual=%0h expected=none",
                         {out_err, out_digit});
            end else begin
                e = exp_q.pop_front();
                chk("entry_digit", int'(out_digit), int'(e[3:0]));
                chk("entry_err", int'(out_err), int'(e[4]));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        seg_in    = 7'h7F;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_digit", int'(out_digit), 0);
        chk("rst_err", int'(out_err), 0);
        chk("rst_overflow", int'(overflow), 0);

        // Single digit 3 with latency check
        vcnt = 0;
        exp_q.push_back({1'b0, 4'h3});
        seg_in = 7'h30;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        chk("lat_before", int'(out_valid), 0);
        @(posedge clock);
        #1;
        chk("lat_at", int'(out_valid), 1);
        hold(7'h30, 2);
        chk("s1_pulse", vcnt, 1);

        // Short glitch then blank: nothing pushed
        vcnt = 0;
        hold(7'h12, 2);
        hold(7'h7F, 6);
        chk("s2_nopush", vcnt, 0);

        // Same digit twice separated by blank
        vcnt = 0;
        exp_q.push_back({1'b0, 4'h1});
        exp_q.push_back({1'b0, 4'h1});
        hold(7'h79, 5);
        hold(7'h7F, 5);
        hold(7'h79, 5);
        hold(7'h7F, 5);
        chk("s3_pulses", vcnt, 2);

        // Overflow: fill with 0..3, digit 4 dropped
        chk("s4_ovf_before", int'(overflow), 0);
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 4'h0});
        exp_q.push_back({1'b0, 4'h1});
        exp_q.push_back({1'b0, 4'h2});
        exp_q.push_back({1'b0, 4'h3});
        hold(7'h40, 5);
        hold(7'h79, 5);
        hold(7'h24, 5);
        hold(7'h30, 5);
        chk("s4_ovf_clear", int'(overflow), 0);
        hold(7'h19, 5);
        chk("s4_ovf_set", int'(overflow), 1);
        chk("s4_valid", int'(out_valid), 1);
        chk("s4_head", int'(out_digit), 0);
        out_ready = 1'b1;
        hold(7'h19, 6);
        chk("s4_drained", int'(out_valid), 0);
        chk("s4_ovf_sticky", int'(overflow), 1);

        // Unknown pattern -> error entry
        exp_q.push_back({1'b1, 4'h0});
        hold(7'h7E, 6);

        // Reset with buffered entries discards them
        out_ready = 1'b0;
        hold(7'h40, 5);
        hold(7'h79, 5);
        hold(7'h24, 5);
        chk("s6_valid_pre", int'(out_valid), 1);
        chk("s6_ovf_pre", int'(overflow), 1);
        reset  = 1'b1;
        seg_in = 7'h7F;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("s6_valid_post", int'(out_valid), 0);
        chk("s6_ovf_post", int'(overflow), 0);
        chk("s6_digit_post", int'(out_digit), 0);
        chk("s6_err_post", int'(out_err), 0);
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 4'hD});
        hold(7'h21, 5);
        hold(7'h7F, 3);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seg_decoder_rx
`default_nettype wire

// File: doc/seg_decoder_rx.md
SEG_DECODER_RX -- requirements
Module: seg_decoder_rx

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive equal samples required to accept a segment pattern; legal range 2..15.
REQ-002 Parameter FIFO_DEPTH, default 4: number of decoded-digit entries buffered; power of two.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 seg_in  input  7  observed display pattern; active-low; bit0=a, bit1=b, ..., bit6=g.
REQ-006 out_digit  output  4  decoded hex value at the FIFO head.
REQ-007 out_err  output  1  FIFO head entry came from a pattern not in the hex table.
REQ-008 out_valid  output  1  FIFO head holds an entry.
REQ-009 out_ready  input  1  consumer accepts the head entry when it is high and out_valid is high.
REQ-010 overflow  output  1  sticky flag: an accepted pattern was dropped because the FIFO was full.

Function
REQ-011 The decode table SHALL be exactly as follows (hex, then seg_in):
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
REQ-012 Pattern 7F (all segments off) SHALL be BLANK; it is never pushed.
REQ-013 Any other pattern not in the table SHALL be pushed with out_err=1 and out_digit=0.
REQ-014 Stability filter:
- seg_in is registered every cycle into samp.
- cnt increments (saturating at STABLE_CYCLES) while seg_in equals samp, and resets to 1 otherwise.
- A pattern is "stable" in the cycle in which cnt reaches STABLE_CYCLES.
REQ-015 FSM states and transitions:
- BLANK: on a stable non-blank pattern, push it and go to LOCKED.
- LOCKED: hold the accepted pattern. On a stable pattern that differs from the accepted pattern, push it if non-blank and stay in LOCKED, or go to BLANK if it is blank. Never re-push an unchanged pattern.
REQ-016 A glitch shorter than STABLE_CYCLES cycles SHALL cause no push and no state change.
REQ-017 Latency: if seg_in changes before edge N and is held, the push occurs at edge N+STABLE_CYCLES-1; with an empty FIFO, out_valid is high after that edge.
REQ-018 The FIFO SHALL be first-word-fall-through; out_digit, out_err and out_valid are driven from registers only.
REQ-019 When a push and a pop occur in the same cycle with the FIFO full, both SHALL succeed and overflow SHALL be unchanged.
REQ-020 A push with the FIFO full and no pop SHALL be dropped, overflow SHALL be set, and FSM tracking SHALL proceed as if the push had succeeded.
REQ-021 A push and a pop in the same cycle with the FIFO empty SHALL leave one entry, the pushed one.
REQ-022 The FIFO SHALL hold at most FIFO_DEPTH entries; read and write pointers wrap modulo FIFO_DEPTH, with one extra bit to distinguish full from empty.

Reset
REQ-023 While reset is high at a clock edge, the following SHALL hold after that edge:
- FSM=BLANK, samp=7F, cnt=1, FIFO empty.
- out_valid=0, out_digit=0, out_err=0, overflow=0.
REQ-024 Reset SHALL take effect at any time, including during a filter count or with the FIFO non-empty; all buffered entries are discarded.
REQ-025 overflow SHALL be cleared only by reset.

Structure
REQ-026 Shared package seg_pkg SHALL hold:
- the 16 pattern constants and SEG_BLANK=7F;
- the FSM state enum (BLANK, LOCKED);
- the FIFO entry type {err, digit[3:0]}.
REQ-027 The decode table SHALL be a combinational sub-module seg_lookup (seg[6:0] -> digit[3:0], hit), the exact inverse of the team's hex_decoder table.

Verification
REQ-028 Directed scenarios the bench SHALL cover:
- Reset, then hold seg_in=30 for 6 cycles with out_ready=1 -> exactly one entry, digit=3, err=0, out_valid pulses high for 1 cycle.
- seg_in=12 for 2 cycles then 7F -> no push, out_valid stays 0.
- Sequence 79(5 cycles), 7F(5), 79(5) with out_ready=1 -> two entries, both digit=1.
- out_ready=0; patterns 40, 79, 24, 30, 19 each held 5 cycles -> FIFO holds 0,1,2,3, overflow=1; the 19 (digit 4) is dropped.
- seg_in=7E held 5 cycles -> entry with err=1, digit=0.
- Assert reset with 3 entries buffered and overflow=1 -> next cycle out_valid=0, overflow=0; a subsequent 21 held 5 cycles yields digit=D.
